// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and Gray/binary helpers for the async FIFO pointer logic
package fifo_pkg;

    localparam int FIFO_ADDR_SIZE = 3;

    // Helpers work on a wide vector; callers zero-extend and truncate to their pointer width.
    localparam int GRAY_W = 32;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
        logic [GRAY_W-1:0] bin;
        logic              acc;
        acc = 1'b0;
        bin = '0;
        for (int i = GRAY_W - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_gray2binary.sv
// rtl/fifo_wr_ctrl_gray2binary.sv - combinational Gray-to-binary decode (MSB-first XOR prefix chain)
module Gray2Binary #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    always_comb begin
        logic acc;
        acc   = 1'b0;
        bin_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc      = acc ^ gray_i[i];
            bin_o[i] = acc;
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-domain pointer, address, level and flag controller for the async FIFO
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter  int ADDR_SIZE = FIFO_ADDR_SIZE,
    localparam int PTR_SIZE  = ADDR_SIZE + 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 W_INC,
    input  logic [PTR_SIZE-1:0]  Gray_SYNC_RD_PTR,
    input  logic [PTR_SIZE-1:0]  AFULL_THRESH,
    input  logic                 OVF_CLR,
    output logic                 W_EN,
    output logic [ADDR_SIZE-1:0] Binary_W_ADDR,
    output logic [PTR_SIZE-1:0]  Gray_WR_PTR,
    output logic                 W_full,
    output logic                 W_almost_full,
    output logic [PTR_SIZE-1:0]  W_level,
    output logic                 W_overflow
);

    logic [PTR_SIZE-1:0] wbin_q, wbin_d;
    logic [PTR_SIZE-1:0] wgray_q, wgray_d;
    logic [PTR_SIZE-1:0] level_q, level_d;
    logic [PTR_SIZE-1:0] rbin;
    logic [PTR_SIZE-1:0] full_pattern;
    logic                full_q, full_d;
    logic                afull_q, afull_d;
    logic                ovf_q, ovf_d;
    logic                write_ok;

    Gray2Binary #(
        .WIDTH (PTR_SIZE)
    ) u_rd_decode (
        .gray_i (Gray_SYNC_RD_PTR),
        .bin_o  (rbin)
    );

    assign write_ok = W_INC & ~full_q;

    // Full when our next Gray pointer equals the read pointer with its two MSBs inverted.
    assign full_pattern = {~Gray_SYNC_RD_PTR[PTR_SIZE-1 -: 2], Gray_SYNC_RD_PTR[PTR_SIZE-3:0]};

    always_comb begin
        wbin_d = wbin_q;
        if (write_ok) begin
            wbin_d = wbin_q + PTR_SIZE'(1);
        end
        wgray_d = PTR_SIZE'(bin2gray(GRAY_W'(wbin_d)));
        level_d = wbin_d - rbin;
        full_d  = (wgray_d == full_pattern);
        afull_d = (level_d >= AFULL_THRESH);
        ovf_d   = (W_INC & full_q) | (ovf_q & ~OVF_CLR);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign W_EN          = write_ok & ~RST;
    assign Binary_W_ADDR = wbin_q[ADDR_SIZE-1:0];
    assign Gray_WR_PTR   = wgray_q;
    assign W_full        = full_q;
    assign W_almost_full = afull_q;
    assign W_level       = level_q;
    assign W_overflow    = ovf_q;

endmodule
